multicycle_control_fsm: RTL and testbench

Main sequencer for the multi-cycle MIPS datapath. It decodes opcode/funct from the instruction register and steps each instruction through fetch, decode, execute, memory and writeback. Each cycle it drives the datapath mux selects, the write enables, and the 3-bit ALUOp consumed by ALU control. It also stalls on a ready-handshaked unified memory and flags illegal opcodes and memory timeouts.

---
 rtl/multicycle_control_fsm.sv | 216 +++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Main control sequencer for the multi-cycle MIPS datapath: steps each instruction
// through fetch/decode/execute/memory/writeback and drives datapath selects and enables.
module multicycle_control_fsm #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic [3:0] state_o,
    output logic       fault
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StExecR   = 4'd2,
        StExecI   = 4'd3,
        StAluWb   = 4'd4,
        StMemAddr = 4'd5,
        StMemRd   = 4'd6,
        StMemWb   = 4'd7,
        StMemWr   = 4'd8,
        StBranch  = 4'd9,
        StJump    = 4'd10,
        StJr      = 4'd11,
        StFault   = 4'd15
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpLui   = 6'b001111;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] FnJr    = 6'b001000;

    localparam logic [7:0] CntLast = 8'(MEM_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       fault_q;
    logic       wait_state;
    logic       timeout;

    logic unused_zero;
    assign unused_zero = zero;

    assign wait_state = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
    // mem_ready in the same cycle wins over the timeout
    assign timeout    = wait_state && !mem_ready && (cnt_q == CntLast);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch: begin
                if (mem_ready)    state_d = StDecode;
                else if (timeout) state_d = StFault;
            end
            StDecode: begin
                unique case (opcode)
                    OpRtype:                     state_d = (funct == FnJr) ? StJr : StExecR;
                    OpAddi, OpAndi, OpOri, OpLui: state_d = StExecI;
                    OpLw, OpSw:                  state_d = StMemAddr;
                    OpBeq, OpBne:                state_d = StBranch;
                    OpJ, OpJal:                  state_d = StJump;
                    default:                     state_d = StFault;
                endcase
            end
            StExecR, StExecI: state_d = StAluWb;
            StMemAddr:        state_d = (opcode == OpSw) ? StMemWr : StMemRd;
            StMemRd: begin
                if (mem_ready)    state_d = StMemWb;
                else if (timeout) state_d = StFault;
            end
            StMemWr: begin
                if (mem_ready)    state_d = StFetch;
                else if (timeout) state_d = StFault;
            end
            StAluWb, StMemWb, StBranch, StJump, StJr: state_d = StFetch;
            StFault:          state_d = StFault;
            default:          state_d = StFault;
        endcase
    end

    always_comb begin
        if (state_d != state_q)           cnt_d = 8'd0;
        else if (wait_state && !mem_ready) cnt_d = cnt_q + 8'd1;
        else                              cnt_d = cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StFetch;
            cnt_q   <= 8'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_q | (state_d == StFault);
        end
    end

    // Moore decode of the state; only the FETCH load enables look at mem_ready
    always_comb begin
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        pc_src        = 2'd0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_op        = 3'b000;
        reg_write     = 1'b0;
        reg_dst       = 2'd0;
        mem_to_reg    = 2'd0;
        unique case (state_q)
            StFetch: begin
                mem_req   = 1'b1;
                alu_src_b = 2'd1;
                alu_op    = 3'b110;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            StDecode: begin
                alu_src_b = 2'd3;
                alu_op    = 3'b110;
            end
            StExecR: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b111;
            end
            StExecI: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                unique case (opcode)
                    OpAndi:  alu_op = 3'b011;
                    OpOri:   alu_op = 3'b101;
                    OpLui:   alu_op = 3'b001;
                    default: alu_op = 3'b110;
                endcase
            end
            StAluWb: begin
                reg_write = 1'b1;
                reg_dst   = (opcode == OpRtype) ? 2'd1 : 2'd0;
            end
            StMemAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu_op    = 3'b010;
            end
            StMemRd: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'd1;
            end
            StMemWr: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            StBranch: begin
                alu_src_a     = 1'b1;
                alu_op        = 3'b100;
                pc_write_cond = 1'b1;
                pc_src        = 2'd1;
                branch_ne     = opcode[0];
            end
            StJump: begin
                pc_write = 1'b1;
                pc_src   = 2'd2;
                if (opcode == OpJal) begin
                    reg_write  = 1'b1;
                    reg_dst    = 2'd2;
                    mem_to_reg = 2'd2;
                end
            end
            StJr: begin
                pc_write = 1'b1;
                pc_src   = 2'd3;
            end
            default: ;
        endcase
    end

    assign state_o = state_q;
    assign fault   = fault_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized self-checking bench: instructions are expanded into per-cycle expected
// state/control tuples from the instruction-class rules and compared against the DUT.
module tb_multicycle_control_fsm;

    localparam int TO = 16;

    localparam int S_FETCH = 0, S_DEC = 1, S_EXR = 2, S_EXI = 3, S_AWB = 4, S_MADDR = 5;
    localparam int S_MRD = 6, S_MWB = 7, S_MWR = 8, S_BR = 9, S_JMP = 10, S_JR = 11;
    localparam int S_FAULT = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0, funct = 6'd0;
    logic       zero = 1'b0, mem_ready = 1'b0;
    logic       mem_req, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, branch_ne;
    logic [1:0] pc_src, alu_src_b, reg_dst, mem_to_reg;
    logic       alu_src_a, reg_write, fault;
    logic [2:0] alu_op;
    logic [3:0] state_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         st;
        logic       rdy;
        logic [5:0] op;
        logic [5:0] fn;
    } step_t;

    step_t q[$];

    multicycle_control_fsm #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .branch_ne(branch_ne), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .state_o(state_o), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [20:0] act_ctrl();
        return {mem_req, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, branch_ne,
                pc_src, alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, fault};
    endfunction

    // Expected control word for one cycle, from the per-state output table
    function automatic logic [20:0] exp_ctrl(input int st, input logic [5:0] op, input logic rdy);
        logic mrq = 0, mwr = 0, iod = 0, irw = 0, pcw = 0, pcc = 0, bne = 0, asa = 0, rw = 0;
        logic flt = 0;
        logic [1:0] psrc = 0, asb = 0, rdst = 0, m2r = 0;
        logic [2:0] aop = 0;
        case (st)
            S_FETCH: begin mrq = 1; asb = 1; aop = 3'b110; irw = rdy; pcw = rdy; end
            S_DEC:   begin asb = 3; aop = 3'b110; end
            S_EXR:   begin asa = 1; aop = 3'b111; end
            S_EXI: begin
                asa = 1; asb = 2;
                aop = (op == 6'd12) ? 3'b011 : (op == 6'd13) ? 3'b101 :
                      (op == 6'd15) ? 3'b001 : 3'b110;
            end
            S_AWB:   begin rw = 1; rdst = (op == 6'd0) ? 2'd1 : 2'd0; end
            S_MADDR: begin asa = 1; asb = 2; aop = 3'b010; end
            S_MRD:   begin mrq = 1; iod = 1; end
            S_MWB:   begin rw = 1; m2r = 1; end
            S_MWR:   begin mrq = 1; mwr = 1; iod = 1; end
            S_BR:    begin asa = 1; aop = 3'b100; pcc = 1; psrc = 1; bne = (op == 6'd5); end
            S_JMP: begin
                pcw = 1; psrc = 2;
                if (op == 6'd3) begin rw = 1; rdst = 2; m2r = 2; end
            end
            S_JR:    begin pcw = 1; psrc = 3; end
            default: flt = 1;
        endcase
        return {mrq, mwr, iod, irw, pcw, pcc, bne, psrc, asa, asb, aop, rw, rdst, m2r, flt};
    endfunction

    task automatic push(input int st, input logic rdy, input logic [5:0] op, input logic [5:0] fn);
        step_t s;
        s.st = st; s.rdy = rdy; s.op = op; s.fn = fn;
        q.push_back(s);
    endtask

    // A memory-waiting state: `w` not-ready cycles, then the completing cycle
    task automatic push_wait(input int st, input int w, input logic [5:0] op, input logic [5:0] fn);
        for (int i = 0; i < w; i++) push(st, 1'b0, op, fn);
        push(st, 1'b1, op, fn);
    endtask

    task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                              input int mw);
        logic r;
        push_wait(S_FETCH, fw, op, fn);
        r = 1'($urandom_range(0, 1));
        push(S_DEC, r, op, fn);
        case (op)
            6'd0: begin
                if (fn == 6'd8) push(S_JR, r, op, fn);
                else begin push(S_EXR, r, op, fn); push(S_AWB, r, op, fn); end
            end
            6'd8, 6'd12, 6'd13, 6'd15: begin push(S_EXI, r, op, fn); push(S_AWB, r, op, fn); end
            6'd35: begin push(S_MADDR, r, op, fn); push_wait(S_MRD, mw, op, fn);
                         push(S_MWB, r, op, fn); end
            6'd43: begin push(S_MADDR, r, op, fn); push_wait(S_MWR, mw, op, fn); end
            6'd4, 6'd5: push(S_BR, r, op, fn);
            6'd2, 6'd3: push(S_JMP, r, op, fn);
            default: begin push(S_FAULT, r, op, fn); push(S_FAULT, ~r, op, fn); end
        endcase
    endtask

    task automatic run_q();
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            @(negedge clk);
            opcode = s.op; funct = s.fn; mem_ready = s.rdy; zero = 1'($urandom_range(0, 1));
            #1;
            check("state", 32'(state_o), 32'(s.st));
            check("ctrl", 32'(act_ctrl()), 32'(exp_ctrl(s.st, s.op, s.rdy)));
        end
    endtask

    // Assert reset mid-cycle and release just after a rising edge so the next
    // instruction starts with a fresh FETCH
    task automatic do_reset();
        @(negedge clk);
        mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_state", 32'(state_o), 32'(S_FETCH));
        check("rst_ctrl", 32'(act_ctrl()), 32'(exp_ctrl(S_FETCH, opcode, 1'b0)));
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        logic [5:0] legal [11];
        logic [5:0] illegal [4];
        logic [5:0] op, fn;
        int fw, mw;
        legal   = '{6'd0, 6'd8, 6'd12, 6'd13, 6'd15, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2, 6'd3};
        illegal = '{6'h3f, 6'h01, 6'h20, 6'h09};

        do_reset();

        // Directed sequences
        push_instr(6'd0, 6'b100000, 0, 0);   // ADD: 0,1,2,4
        push_instr(6'd35, 6'd0, 0, 2);       // LW with two memory waits
        push_instr(6'd5, 6'd0, 0, 0);        // BNE
        push_instr(6'd3, 6'd0, 0, 0);        // JAL
        push_instr(6'd0, 6'd8, 1, 0);        // JR after one fetch wait
        push_instr(6'd13, 6'd0, 0, 0);       // ORI
        push_instr(6'd43, 6'd0, 0, TO - 1);  // SW: ready arrives on the last allowed cycle
        push_instr(6'd0, 6'd0, TO - 1, 0);   // fetch ready on the last allowed cycle
        push_instr(6'h3f, 6'd0, 0, 0);       // illegal opcode
        run_q();
        do_reset();

        // Fetch timeout: 16 not-ready cycles, then sticky FAULT
        for (int i = 0; i < TO; i++) push(S_FETCH, 1'b0, 6'd0, 6'd0);
        for (int i = 0; i < 3; i++) push(S_FAULT, 1'(i), 6'd0, 6'd0);
        run_q();
        do_reset();

        // Read timeout in MEM_RD
        push(S_FETCH, 1'b1, 6'd35, 6'd0);
        push(S_DEC, 1'b0, 6'd35, 6'd0);
        push(S_MADDR, 1'b0, 6'd35, 6'd0);
        for (int i = 0; i < TO; i++) push(S_MRD, 1'b0, 6'd35, 6'd0);
        push(S_FAULT, 1'b1, 6'd35, 6'd0);
        run_q();
        do_reset();

        // Reset while a store is waiting in MEM_WR
        push(S_FETCH, 1'b1, 6'd43, 6'd0);
        push(S_DEC, 1'b1, 6'd43, 6'd0);
        push(S_MADDR, 1'b1, 6'd43, 6'd0);
        push(S_MWR, 1'b0, 6'd43, 6'd0);
        run_q();
        do_reset();
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_reg_write", 32'(reg_write), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);

        // Random instruction stream
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 19) == 0) op = illegal[$urandom_range(0, 3)];
            else op = legal[$urandom_range(0, 10)];
            fn = ($urandom_range(0, 3) == 0) ? 6'd8 : 6'($urandom_range(0, 63));
            fw = ($urandom_range(0, 9) == 0) ? $urandom_range(0, TO - 1) : $urandom_range(0, 2);
            mw = ($urandom_range(0, 9) == 0) ? $urandom_range(0, TO - 1) : $urandom_range(0, 2);
            push_instr(op, fn, fw, mw);
            run_q();
            if (op == 6'h3f || op == 6'h01 || op == 6'h20 || op == 6'h09) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
